fetch_instr_queue: RTL and testbench
====================================

Name: fetch_instr_queue

Overview:
- Two-wide, in-order instruction queue that receives the fetch stage's two output slots (pc, instr, guesses_branch, prediction per slot).
- Buffers the slots and presents up to two instructions per cycle to decode.
- Back-pressures fetch through stall_out, which drives the fetch stage's ext_stall.
- Sits between fetch and decode; flushed on branch redirect together with fetch.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- ADDR_WIDTH, `ADDR_WIDTH (32), width of pc and prediction fields.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all queued and incoming instructions
- in_valid  input  2  per-slot valid from fetch; bit0 = slot0 (older)
- in_pc0, in_pc1  input  ADDR_WIDTH  slot pc
- in_instr0, in_instr1  input  32  slot instruction word
- in_guess0, in_guess1  input  1  slot guesses_branch
- in_pred0, in_pred1  input  ADDR_WIDTH  slot predicted next pc
- stall_out  output  1  queue cannot accept two entries; fetch must hold its outputs
- dec_ready  input  1  decode consumes every out slot that is valid this cycle
- out_valid  output  2  bit0 = head valid, bit1 = head+1 valid
- out_pc0, out_pc1  output  ADDR_WIDTH  head / head+1 pc
- out_instr0, out_instr1  output  32  head / head+1 instruction word
- out_guess0, out_guess1  output  1  head / head+1 guesses_branch
- out_pred0, out_pred1  output  ADDR_WIDTH  head / head+1 prediction
- occupancy  output  $clog2(DEPTH)+1  registered entry count

Behaviour:
- Circular buffer:
  - head and tail pointers are $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits.
- Reset (highest priority):
  - head, tail and count go to 0; all storage fields go to 0.
  - Outputs after reset: out_valid=2'b00, stall_out=0, occupancy=0, all out_* data = 0.
- stall_out:
  - Combinational from the registered count: stall_out = (DEPTH - count) < 2.
  - It never depends on dec_ready or in_valid, so there is no combinational path from decode to fetch.
- Enqueue (only when !stall_out and !flush):
  - in_valid 2'b11: slot0 written at tail, slot1 at tail+1; tail += 2.
  - 2'b01: slot0 written at tail; tail += 1.
  - 2'b10: slot1 written at tail (compacted); tail += 1.
  - 2'b00: no write.
  - When stall_out=1, inputs are ignored. Fetch holds them and re-presents them, so nothing is lost.
- Output:
  - out_valid[0] = (count >= 1); out_valid[1] = (count >= 2).
  - Data is read combinationally from storage at head and head+1.
  - Minimum latency is 1 cycle: an entry written in cycle N is visible in cycle N+1. There is no bypass.
- Dequeue (when dec_ready and !flush):
  - head advances by popcount(out_valid), i.e. 0, 1 or 2.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n.
  - Both operations use the registered count.
  - Enqueue is still gated by the pre-dequeue stall_out.
- flush:
  - Next cycle: head=tail=0, count=0.
  - Enqueue and dequeue in the flush cycle are suppressed.
  - Storage contents are not cleared, since the valids gate them.
- Wrap-around: a two-entry write or read starting at index DEPTH-1 uses indices DEPTH-1 and 0.
- Invariants (asserted in simulation):
  - count never exceeds DEPTH.
  - count never underflows.
  - Order is preserved: slot0 before slot1, older cycles before newer.

Decomposition:
- Shared package (riscv_core package / riscv_core.svh) holds:
  - `ADDR_WIDTH.
  - fetch_entry_t struct {pc, instr, guesses_branch, prediction}.
  - Storage is an array of fetch_entry_t.
- One natural sub-module, fiq_ptr_ctrl:
  - Owns the head/tail/count update and stall/valid generation.
  - Takes enq_n and deq_n as inputs.
  - The top level does storage writes/reads and slot compaction.

Test Plan:
- Reset, then in_valid=11 with pc0=0x10, pc1=0x14 and dec_ready=0 -> next cycle out_valid=11, out_pc0=0x10, out_pc1=0x14, occupancy=2.
- in_valid=10 with pc1=0x24 into an empty queue -> next cycle out_valid=01, out_pc0=0x24, occupancy=1.
- DEPTH=8, dec_ready=0, in_valid=11 on 4 consecutive cycles -> occupancy=8 and stall_out=1; a fifth pair held by the bench is not written; after one dec_ready cycle, occupancy=6 and stall_out=0.
- Fill to occupancy 7, then dec_ready=1 with in_valid=11 in the same cycle -> stall_out=1 was high, so no enqueue; occupancy=5 next cycle and stall_out drops.
- flush while occupancy=5, in_valid=11 and dec_ready=1 -> next cycle occupancy=0, out_valid=00, head=tail=0, and no flushed pc ever appears.
- Stream 40 random pairs with random in_valid and random dec_ready -> pointers wrap several times; the scoreboard sees exact pc order and a gapless instruction sequence.

Source files
------------

// File: rtl/fetch_instr_queue_pkg.sv
// Shared types and constants for the fetch instruction queue.
//
// FIQ_ADDR_WIDTH  : width of pc and prediction fields
// FIQ_INSTR_WIDTH : width of one instruction word
// fetch_entry_t   : one buffered fetch slot {pc, instr, guesses_branch, prediction}
// popcount2       : number of set bits in a two-bit slot-valid vector
package fetch_instr_queue_pkg;

    localparam int FIQ_ADDR_WIDTH  = 32;
    localparam int FIQ_INSTR_WIDTH = 32;

    typedef struct packed {
        logic [FIQ_ADDR_WIDTH-1:0]  pc;
        logic [FIQ_INSTR_WIDTH-1:0] instr;
        logic                       guesses_branch;
        logic [FIQ_ADDR_WIDTH-1:0]  prediction;
    } fetch_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/fetch_instr_queue_ptr_ctrl.sv
// Pointer / occupancy bookkeeping for the fetch instruction queue.
//
// clk, reset : clock, synchronous active-high reset
// flush      : return head, tail and count to zero next cycle
// enq_n      : entries written this cycle (0..2), already gated by stall/flush
// deq_n      : entries consumed this cycle (0..2), already gated by flush
// head, tail : read / write indices, wrap modulo DEPTH
// count      : registered entry count
// stall      : fewer than two free entries remain
// out_valid  : bit0 = at least one entry, bit1 = at least two entries
module fiq_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [1:0]    enq_n,
    input  logic [1:0]    deq_n,
    output logic [PW-1:0] head,
    output logic [PW-1:0] tail,
    output logic [CW-1:0] count,
    output logic          stall,
    output logic [1:0]    out_valid
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Derived only from registered count, so decode readiness never
    // reaches fetch combinationally.
    assign stall     = (DEPTH_C - count) < CW'(2);
    assign out_valid = {count >= CW'(2), count != '0};

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_n);
            count <= count + CW'(enq_n) - CW'(deq_n);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= DEPTH_C);
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        CW'(deq_n) <= count);
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (count + CW'(enq_n) - CW'(deq_n)) <= DEPTH_C);
    // Entries occupy head..tail-1 contiguously, which is what keeps order.
    a_ptr_consistent: assert property (@(posedge clk) disable iff (reset)
        tail == head + count[PW-1:0]);

endmodule

// File: rtl/fetch_instr_queue.sv
// Two-wide in-order queue between fetch and decode.
//
// clk, reset          : clock, synchronous active-high reset
// flush               : drop queued and incoming slots (branch redirect)
// in_valid            : per-slot valid from fetch, bit0 = older slot
// in_pc/instr/guess/pred{0,1} : fetch slot fields
// stall_out           : fewer than two free entries; fetch holds its slots
// dec_ready           : decode takes every valid out slot this cycle
// out_valid           : bit0 = head valid, bit1 = head+1 valid
// out_pc/instr/guess/pred{0,1} : entry at head / head+1
// occupancy           : registered entry count
module fetch_instr_queue
    import fetch_instr_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = FIQ_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [1:0]              in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_pc0,
    input  logic [ADDR_WIDTH-1:0]   in_pc1,
    input  logic [31:0]             in_instr0,
    input  logic [31:0]             in_instr1,
    input  logic                    in_guess0,
    input  logic                    in_guess1,
    input  logic [ADDR_WIDTH-1:0]   in_pred0,
    input  logic [ADDR_WIDTH-1:0]   in_pred1,
    output logic                    stall_out,
    input  logic                    dec_ready,
    output logic [1:0]              out_valid,
    output logic [ADDR_WIDTH-1:0]   out_pc0,
    output logic [ADDR_WIDTH-1:0]   out_pc1,
    output logic [31:0]             out_instr0,
    output logic [31:0]             out_instr1,
    output logic                    out_guess0,
    output logic                    out_guess1,
    output logic [ADDR_WIDTH-1:0]   out_pred0,
    output logic [ADDR_WIDTH-1:0]   out_pred1,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    logic [CW-1:0] count;
    logic          stall;
    logic [1:0]    valid;
    logic [1:0]    enq_n;
    logic [1:0]    deq_n;

    fetch_entry_t mem [DEPTH];
    fetch_entry_t slot0;
    fetch_entry_t slot1;
    fetch_entry_t wr_first;
    fetch_entry_t rd0;
    fetch_entry_t rd1;

    fiq_ptr_ctrl #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_ptr (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_n     (enq_n),
        .deq_n     (deq_n),
        .head      (head),
        .tail      (tail),
        .count     (count),
        .stall     (stall),
        .out_valid (valid)
    );

    assign slot0 = '{pc: in_pc0, instr: in_instr0, guesses_branch: in_guess0, prediction: in_pred0};
    assign slot1 = '{pc: in_pc1, instr: in_instr1, guesses_branch: in_guess1, prediction: in_pred1};

    // A lone slot1 is compacted down to the tail position.
    assign wr_first = in_valid[0] ? slot0 : slot1;

    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);

    // Enqueue uses the stall seen before this cycle's dequeue.
    always_comb begin
        enq_n = 2'd0;
        if (!stall && !flush) begin
            enq_n = popcount2(in_valid);
        end
    end

    always_comb begin
        deq_n = 2'd0;
        if (dec_ready && !flush) begin
            deq_n = popcount2(valid);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (enq_n != 2'd0) begin
                mem[tail] <= wr_first;
            end
            if (enq_n == 2'd2) begin
                mem[tail_p1] <= slot1;
            end
        end
    end

    assign rd0 = mem[head];
    assign rd1 = mem[head_p1];

    assign out_valid  = valid;
    assign stall_out  = stall;
    assign occupancy  = count;
    assign out_pc0    = rd0.pc;
    assign out_pc1    = rd1.pc;
    assign out_instr0 = rd0.instr;
    assign out_instr1 = rd1.instr;
    assign out_guess0 = rd0.guesses_branch;
    assign out_guess1 = rd1.guesses_branch;
    assign out_pred0  = rd0.prediction;
    assign out_pred1  = rd1.prediction;

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: directed scenarios with literal expectations,
// a queue-based reference model compared every cycle, and a random stream
// whose instruction words are a gapless sequence number.
module tb_fetch_instr_queue;

    localparam int DEPTH = 8;
    localparam logic [31:0] SEQ_BASE = 32'h0000_8000;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_pc0, in_pc1, in_instr0, in_instr1, in_pred0, in_pred1;
    logic        in_guess0, in_guess1;
    logic        stall_out;
    logic        dec_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0, out_pc1, out_instr0, out_instr1, out_pred0, out_pred1;
    logic        out_guess0, out_guess1;
    logic [3:0]  occupancy;

    fetch_instr_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc0     (in_pc0),
        .in_pc1     (in_pc1),
        .in_instr0  (in_instr0),
        .in_instr1  (in_instr1),
        .in_guess0  (in_guess0),
        .in_guess1  (in_guess1),
        .in_pred0   (in_pred0),
        .in_pred1   (in_pred1),
        .stall_out  (stall_out),
        .dec_ready  (dec_ready),
        .out_valid  (out_valid),
        .out_pc0    (out_pc0),
        .out_pc1    (out_pc1),
        .out_instr0 (out_instr0),
        .out_instr1 (out_instr1),
        .out_guess0 (out_guess0),
        .out_guess1 (out_guess1),
        .out_pred0  (out_pred0),
        .out_pred1  (out_pred1),
        .occupancy  (occupancy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [96:0] exp_q[$];     // {pc, instr, guess, pred}, oldest first
    bit          check_seq = 0;
    int          seq_exp = 0;
    int          seq_gen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A plain FIFO of entries: drop on reset/flush, pop what decode takes,
    // push the valid slots in order when at least two entries are free.
    always @(posedge clk) begin
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            bit room;
            int take;
            room = (DEPTH - exp_q.size()) >= 2;
            take = 0;
            if (dec_ready) take = (exp_q.size() >= 2) ? 2 : exp_q.size();
            for (int k = 0; k < take; k++) void'(exp_q.pop_front());
            if (room) begin
                if (in_valid[0]) exp_q.push_back({in_pc0, in_instr0, in_guess0, in_pred0});
                if (in_valid[1]) exp_q.push_back({in_pc1, in_instr1, in_guess1, in_pred1});
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            int n;
            n = exp_q.size();
            chk("occupancy", occupancy, n);
            chk("out_valid", out_valid, {n >= 2, n >= 1});
            chk("stall_out", stall_out, (DEPTH - n) < 2);
            if (n >= 1) chk("slot0_data", {out_pc0, out_instr0, out_guess0, out_pred0}, exp_q[0]);
            if (n >= 2) chk("slot1_data", {out_pc1, out_instr1, out_guess1, out_pred1}, exp_q[1]);
            if (check_seq && dec_ready && !flush) begin
                if (out_valid[0]) begin
                    chk("seq_instr0", out_instr0, seq_exp);
                    chk("seq_pc0", out_pc0, SEQ_BASE + 32'(seq_exp * 4));
                    seq_exp++;
                end
                if (out_valid[1]) begin
                    chk("seq_instr1", out_instr1, seq_exp);
                    chk("seq_pc1", out_pc1, SEQ_BASE + 32'(seq_exp * 4));
                    seq_exp++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slots(input logic [1:0] v,
                               input logic [31:0] pc0, input logic [31:0] i0, input logic g0, input logic [31:0] p0,
                               input logic [31:0] pc1, input logic [31:0] i1, input logic g1, input logic [31:0] p1,
                               input logic dr, input logic fl);
        in_valid  = v;
        in_pc0    = pc0;  in_instr0 = i0;  in_guess0 = g0;  in_pred0 = p0;
        in_pc1    = pc1;  in_instr1 = i1;  in_guess1 = g1;  in_pred1 = p1;
        dec_ready = dr;
        flush     = fl;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic dr, input logic fl);
        drive_slots(v, pc0, pc0 ^ 32'hA5A5_0000, pc0[2], pc0 + 32'd64,
                       pc1, pc1 ^ 32'hA5A5_0000, pc1[2], pc1 + 32'd64, dr, fl);
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 2'b00);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_occupancy", occupancy, 4'd0);
        chk("rst_out_pc0", out_pc0, 32'h0);
        chk("rst_out_instr1", out_instr1, 32'h0);

        // pair into empty queue, decode idle
        drive(2'b11, 32'h10, 32'h14, 1'b0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("pair_valid", out_valid, 2'b11);
        chk("pair_pc0", out_pc0, 32'h10);
        chk("pair_pc1", out_pc1, 32'h14);
        chk("pair_occ", occupancy, 4'd2);
        do_flush();

        // lone slot1 compacts to head
        drive(2'b10, 32'h0, 32'h24, 1'b0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("compact_valid", out_valid, 2'b01);
        chk("compact_pc0", out_pc0, 32'h24);
        chk("compact_occ", occupancy, 4'd1);
        do_flush();

        // fill to full, then a held fifth pair
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i), 1'b0, 1'b0);
            tick();
        end
        idle();
        @(negedge clk);
        chk("full_occ", occupancy, 4'd8);
        chk("full_stall", stall_out, 1'b1);
        drive(2'b11, 32'h200, 32'h204, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("held_occ", occupancy, 4'd8);
        dec_ready = 1'b1;
        tick();
        idle();
        @(negedge clk);
        chk("drain_occ", occupancy, 4'd6);
        chk("drain_stall", stall_out, 1'b0);
        chk("drain_pc0", out_pc0, 32'h108);

        // occupancy 7: stall gates enqueue even while decode frees two
        drive(2'b01, 32'h300, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("seven_occ", occupancy, 4'd7);
        chk("seven_stall", stall_out, 1'b1);
        drive(2'b11, 32'h400, 32'h404, 1'b1, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("five_occ", occupancy, 4'd5);
        chk("five_stall", stall_out, 1'b0);
        chk("five_pc0", out_pc0, 32'h110);

        // flush beats enqueue and dequeue
        drive(2'b11, 32'h500, 32'h504, 1'b1, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("flush_occ", occupancy, 4'd0);
        chk("flush_valid", out_valid, 2'b00);
        chk("flush_head", dut.u_ptr.head, 3'd0);
        chk("flush_tail", dut.u_ptr.tail, 3'd0);
        repeat (3) tick();

        // random stream: fetch holds a pair until it is accepted
        check_seq = 1;
        begin
            int pairs_sent;
            bit pending;
            logic [1:0] v;
            logic [31:0] pc0, pc1, i0, i1;
            pairs_sent = 0;
            pending = 0;
            v = 2'b00;
            pc0 = '0; pc1 = '0; i0 = '0; i1 = '0;
            for (int cyc = 0; cyc < 2000 && pairs_sent < 40; cyc++) begin
                bit accepted;
                if (!pending) begin
                    v = 2'($urandom_range(0, 3));
                    pc0 = 32'hDEAD_0000; i0 = 32'hFFFF_FFFF;
                    pc1 = 32'hBEEF_0000; i1 = 32'hFFFF_FFFF;
                    if (v[0]) begin
                        i0 = 32'(seq_gen); pc0 = SEQ_BASE + 32'(seq_gen * 4); seq_gen++;
                    end
                    if (v[1]) begin
                        i1 = 32'(seq_gen); pc1 = SEQ_BASE + 32'(seq_gen * 4); seq_gen++;
                    end
                    pending = 1;
                end
                drive_slots(v, pc0, i0, i0[0], pc0 + 32'd8, pc1, i1, i1[0], pc1 + 32'd8,
                            1'($urandom_range(0, 1)), 1'b0);
                accepted = !stall_out;
                tick();
                if (accepted) begin
                    pending = 0;
                    pairs_sent++;
                end
            end
            chk("stream_pairs_sent", pairs_sent, 40);
        end
        idle();
        dec_ready = 1'b1;
        for (int k = 0; k < 40 && occupancy != 0; k++) tick();
        dec_ready = 1'b0;
        @(negedge clk);
        chk("stream_empty", occupancy, 4'd0);
        chk("stream_gapless", seq_exp, seq_gen);
        check_seq = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
